// File: rtl/note_arbiter.sv
// Arbitrates the tone generator between the demo sequencer and the keypad.
// Keypad preempts. A silent gap is inserted on every note/owner change.
module note_arbiter #(
    parameter int GAP_CYCLES = 238,
    parameter int HOLD_MIN   = 23810
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_seq_req,
    input  logic [3:0] i_seq_octave,
    input  logic [3:0] i_seq_note,
    input  logic       i_key_req,
    input  logic [3:0] i_key_octave,
    input  logic [3:0] i_key_note,
    input  logic       i_mute,
    output logic       o_gnt_seq,
    output logic       o_gnt_key,
    output logic       o_seq_pause,
    output logic [3:0] o_octave_out,
    output logic [3:0] o_note_out,
    output logic       o_tone_en
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int HW = $clog2(HOLD_MIN + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEQ, S_KEY, S_GAP} state_t;

    state_t        r_state, r_tgt;
    state_t        w_retgt, w_nstate, w_ntgt;
    logic [GW-1:0] r_gap;
    logic [HW-1:0] r_hold;
    logic [3:0]    w_oct_n, w_note_n;
    logic          w_seq_diff, w_key_diff, w_hold_done;

    assign w_seq_diff  = {i_seq_octave, i_seq_note} != {o_octave_out, o_note_out};
    assign w_key_diff  = {i_key_octave, i_key_note} != {o_octave_out, o_note_out};
    assign w_hold_done = r_hold == HW'(HOLD_MIN);

    // Target re-evaluation while in GAP; the gap counter is never restarted.
    always_comb begin
        w_retgt = r_tgt;
        if (i_key_req)
            w_retgt = S_KEY;
        else if (r_tgt == S_KEY)
            w_retgt = i_seq_req ? S_SEQ : S_IDLE;
        else if (r_tgt == S_SEQ && !i_seq_req)
            w_retgt = S_IDLE;
    end

    always_comb begin
        w_nstate = r_state;
        w_ntgt   = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (i_key_req) begin
                    w_nstate = S_GAP; w_ntgt = S_KEY;
                end else if (i_seq_req) begin
                    w_nstate = S_GAP; w_ntgt = S_SEQ;
                end
            end
            S_SEQ: begin
                if (i_key_req) begin
                    w_nstate = S_GAP; w_ntgt = S_KEY;
                end else if (!i_seq_req) begin
                    w_nstate = S_IDLE;
                end else if (w_seq_diff) begin
                    w_nstate = S_GAP; w_ntgt = S_SEQ;
                end
            end
            S_KEY: begin
                if (!i_key_req && w_hold_done) begin
                    if (i_seq_req) begin
                        w_nstate = S_GAP; w_ntgt = S_SEQ;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end else if (i_key_req && w_key_diff) begin
                    w_nstate = S_GAP; w_ntgt = S_KEY;
                end
            end
            default: begin
                if (r_gap == '0) begin
                    w_nstate = w_retgt;
                end else begin
                    w_ntgt = w_retgt;
                end
            end
        endcase
    end

    // Owned note is latched on entry to SEQ/KEY and held until leaving.
    always_comb begin
        w_oct_n  = 4'd0;
        w_note_n = 4'd0;
        if (w_nstate == S_SEQ) begin
            if (r_state == S_SEQ) begin
                w_oct_n = o_octave_out; w_note_n = o_note_out;
            end else begin
                w_oct_n = i_seq_octave; w_note_n = i_seq_note;
            end
        end else if (w_nstate == S_KEY) begin
            if (r_state == S_KEY) begin
                w_oct_n = o_octave_out; w_note_n = o_note_out;
            end else begin
                w_oct_n = i_key_octave; w_note_n = i_key_note;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_tgt        <= S_IDLE;
            r_gap        <= '0;
            r_hold       <= '0;
            o_gnt_seq    <= 1'b0;
            o_gnt_key    <= 1'b0;
            o_seq_pause  <= 1'b0;
            o_octave_out <= 4'd0;
            o_note_out   <= 4'd0;
            o_tone_en    <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_tgt   <= w_ntgt;
            if (w_nstate == S_GAP && r_state != S_GAP)
                r_gap <= GW'(GAP_CYCLES - 1);
            else if (r_state == S_GAP && r_gap != '0)
                r_gap <= r_gap - 1'b1;
            if (w_nstate == S_KEY && r_state != S_KEY)
                r_hold <= '0;
            else if (r_state == S_KEY && !w_hold_done)
                r_hold <= r_hold + 1'b1;
            o_gnt_seq    <= w_nstate == S_SEQ;
            o_gnt_key    <= w_nstate == S_KEY;
            o_seq_pause  <= (w_nstate == S_KEY) || (w_nstate == S_GAP && w_ntgt == S_KEY);
            o_octave_out <= w_oct_n;
            o_note_out   <= w_note_n;
            o_tone_en    <= (w_nstate == S_SEQ || w_nstate == S_KEY) && w_note_n != 4'd0 && !i_mute;
        end
    end
endmodule
